// File: rtl/input_mapper_pkg.sv
// input_mapper_pkg: shared types and constants for the keyboard/joystick mapper.
//   - slot numbers inside a button's map entry group
//   - map_entry_t : one key-slot table entry {valid, any_ext, code[8:0]}
//   - state_t     : scan FSM states
//   - key_match() : compare of a key-slot entry against a PS/2 code
package input_mapper_pkg;

  localparam logic [1:0] SLOT_KEY_A = 2'd0;
  localparam logic [1:0] SLOT_KEY_B = 2'd1;
  localparam logic [1:0] SLOT_JOY   = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       any_ext;
    logic [8:0] code;
  } map_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Low byte must always match; the extended bit is a don't-care when any_ext is set.
  function automatic logic key_match(input map_entry_t e, input logic [8:0] code);
    return e.valid && (e.code[7:0] == code[7:0]) && (e.any_ext || (e.code[8] == code[8]));
  endfunction

endpackage

// File: rtl/input_mapper_if.sv
// input_mapper_if: bundles the mapper's key/joystick inputs, table write port
// and button outputs.
//   master : the host side (hps_io / test bench) - drives keys, joystick, table
//   slave  : the mapper itself
// Handshake: there is no backpressure anywhere. map_wr is a single-cycle write
// strobe qualified by map_addr/map_data in the same cycle; a PS/2 event is a
// change of ps2_key[10] with ps2_key[9:0] valid in that same cycle.
interface input_mapper_if #(
  parameter int NUM_BTN = 8,
  parameter int JOY_W   = 16
) ();
  import input_mapper_pkg::*;

  localparam int AW = $clog2(NUM_BTN) + 2;

  logic [10:0]        ps2_key;
  logic [JOY_W-1:0]   joy;
  logic               map_wr;
  logic [AW-1:0]      map_addr;
  logic [10:0]        map_data;
  logic [NUM_BTN-1:0] btn_n;
  logic               busy;
  logic               overflow;
  state_t             dbg_state;

  modport master (
    output ps2_key, joy, map_wr, map_addr, map_data,
    input  btn_n, busy, overflow, dbg_state
  );

  modport slave (
    input  ps2_key, joy, map_wr, map_addr, map_data,
    output btn_n, busy, overflow, dbg_state
  );
endinterface

// File: rtl/input_map_table.sv
// input_map_table: NUM_BTN x 3 map entry register file.
//   clk, rst_n        : clock, async active-low reset (all entries invalid)
//   wr_en/addr/data   : write port, addr = {button, slot}; slot 3 is ignored
//   rd_idx, rd_a/rd_b : combinational read of key slots A/B of one button
//   joy_vld/joy_bit   : joystick slot of every button, read in parallel
module input_map_table
  import input_mapper_pkg::*;
#(
  parameter int NUM_BTN = 8,
  parameter int IW      = 3,
  parameter int AW      = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [10:0]              wr_data,
  input  logic [IW-1:0]            rd_idx,
  output map_entry_t               rd_a,
  output map_entry_t               rd_b,
  output logic [NUM_BTN-1:0]       joy_vld,
  output logic [NUM_BTN-1:0][4:0]  joy_bit
);

  logic [AW-1:0] wr_btn;
  logic [1:0]    wr_slot;
  assign wr_btn  = wr_addr >> 2;
  assign wr_slot = wr_addr[1:0];

  map_entry_t [NUM_BTN-1:0] tbl_a;
  map_entry_t [NUM_BTN-1:0] tbl_b;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic       sel;
    map_entry_t ent_a;
    map_entry_t ent_b;
    logic       jv;
    logic [4:0] jb;

    assign sel = wr_en && (wr_btn == AW'(b));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ent_a <= '0;
        ent_b <= '0;
        jv    <= 1'b0;
        jb    <= '0;
      end else if (sel) begin
        case (wr_slot)
          SLOT_KEY_A: ent_a <= map_entry_t'(wr_data);
          SLOT_KEY_B: ent_b <= map_entry_t'(wr_data);
          SLOT_JOY: begin
            // Joystick entries carry only {valid, bit[4:0]}; the middle bits are zero.
            jv <= wr_data[10];
            jb <= wr_data[4:0];
          end
          default: ;
        endcase
      end
    end

    assign tbl_a[b]   = ent_a;
    assign tbl_b[b]   = ent_b;
    assign joy_vld[b] = jv;
    assign joy_bit[b] = jb;
  end

  assign rd_a = tbl_a[rd_idx];
  assign rd_b = tbl_b[rd_idx];

endmodule

// File: rtl/input_mapper.sv
// input_mapper: maps PS/2 key events and joystick bits to an active-low button
// vector through a run-time programmable table.
//   clk_25  : system clock
//   RESET_L : async active-low reset
//   bus     : input_mapper_if slave - ps2_key, joy, map_wr/addr/data in;
//             btn_n (registered), busy (scan running), overflow (sticky drop),
//             dbg_state (scan FSM state) out
// A key event is scanned against every button, one per cycle; one further
// event can wait in a pending slot, anything beyond that is dropped.
module input_mapper
  import input_mapper_pkg::*;
#(
  parameter int                 NUM_BTN    = 8,
  parameter int                 JOY_W      = 16,
  parameter logic [NUM_BTN-1:0] PULSE_MASK = NUM_BTN'(8'b0000_0100),
  parameter int                 PULSE_CYC  = 16
) (
  input logic           clk_25,
  input logic           RESET_L,
  input_mapper_if.slave bus
);

  localparam int             IW         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int             AW         = $clog2(NUM_BTN) + 2;
  localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_BTN - 1);
  localparam logic [7:0]     PULSE_LOAD = 8'(PULSE_CYC - 1);

  // Event detect: the toggle bit differs from its last sampled value.
  logic       old_tgl;
  logic       ev_v;
  logic [9:0] ev_data;
  assign ev_v    = bus.ps2_key[10] != old_tgl;
  assign ev_data = bus.ps2_key[9:0];

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [9:0]    cur, cur_nxt;       // {pressed, code} being scanned
  logic          pend_v, pend_v_nxt;
  logic [9:0]    pend, pend_nxt;
  logic          ovf, ovf_nxt;

  map_entry_t                ent_a, ent_b;
  logic [NUM_BTN-1:0]        joy_vld;
  logic [NUM_BTN-1:0][4:0]   joy_bit;

  input_map_table #(.NUM_BTN(NUM_BTN), .IW(IW), .AW(AW)) u_table (
    .clk     (clk_25),
    .rst_n   (RESET_L),
    .wr_en   (bus.map_wr),
    .wr_addr (bus.map_addr),
    .wr_data (bus.map_data),
    .rd_idx  (idx),
    .rd_a    (ent_a),
    .rd_b    (ent_b),
    .joy_vld (joy_vld),
    .joy_bit (joy_bit)
  );

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cur_nxt    = cur;
    pend_v_nxt = pend_v;
    pend_nxt   = pend;
    ovf_nxt    = ovf;
    case (state)
      IDLE: begin
        if (pend_v) begin
          // The waiting event goes first; a same-cycle new event takes its place.
          state_nxt  = SCAN;
          idx_nxt    = '0;
          cur_nxt    = pend;
          pend_v_nxt = ev_v;
          pend_nxt   = ev_data;
        end else if (ev_v) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
          cur_nxt   = ev_data;
        end
      end
      SCAN: begin
        if (ev_v) begin
          if (pend_v) begin
            ovf_nxt = 1'b1;
          end else begin
            pend_v_nxt = 1'b1;
            pend_nxt   = ev_data;
          end
        end
        if (idx == LAST_IDX) begin
          idx_nxt = '0;
          if (pend_v) begin
            // Chain straight into the next scan so busy has no gap.
            cur_nxt    = pend;
            pend_v_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key state: [b][0] = slot A held, [b][1] = slot B held.
  logic [NUM_BTN-1:0][1:0] kst, kst_nxt;

  always_comb begin
    kst_nxt = kst;
    if (state == SCAN) begin
      if (key_match(ent_a, cur[8:0])) kst_nxt[idx][0] = cur[9];
      if (key_match(ent_b, cur[8:0])) kst_nxt[idx][1] = cur[9];
    end
  end

  // Out-of-range joystick bit indices land on the zero padding.
  logic [31:0]        joy_pad;
  logic [NUM_BTN-1:0] p_raw;
  always_comb begin
    joy_pad              = '0;
    joy_pad[JOY_W-1:0]   = bus.joy;
    p_raw                = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      p_raw[b] = kst_nxt[b][0] | kst_nxt[b][1] | (joy_vld[b] & joy_pad[joy_bit[b]]);
    end
  end

  // Raw press is taken from the next-state key bits so btn_n registers the
  // compare result directly: compare in cycle t, output visible in t+1.
  logic [NUM_BTN-1:0] p_final;
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_out
    if (PULSE_MASK[b]) begin : g_str
      logic       p_q;
      logic [7:0] cnt;
      logic       rise;
      assign rise = p_raw[b] & ~p_q;
      always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
          p_q <= 1'b0;
          cnt <= '0;
        end else begin
          p_q <= p_raw[b];
          if (rise)             cnt <= PULSE_LOAD;
          else if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
      end
      assign p_final[b] = p_raw[b] | (cnt != 8'd0) | rise;
    end else begin : g_plain
      assign p_final[b] = p_raw[b];
    end
  end

  logic [NUM_BTN-1:0] btn_n_q;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      old_tgl <= 1'b0;
      state   <= IDLE;
      idx     <= '0;
      cur     <= '0;
      pend_v  <= 1'b0;
      pend    <= '0;
      ovf     <= 1'b0;
      kst     <= '0;
      btn_n_q <= '1;
    end else begin
      old_tgl <= bus.ps2_key[10];
      state   <= state_nxt;
      idx     <= idx_nxt;
      cur     <= cur_nxt;
      pend_v  <= pend_v_nxt;
      pend    <= pend_nxt;
      ovf     <= ovf_nxt;
      kst     <= kst_nxt;
      btn_n_q <= ~p_final;
    end
  end

  assign bus.btn_n     = btn_n_q;
  assign bus.busy      = (state != IDLE);
  assign bus.overflow  = ovf;
  assign bus.dbg_state = state;

endmodule

// File: doc/input_mapper.md
# input_mapper

Parametrised keyboard/joystick-to-button mapper that replaces the hard-coded PS/2 `casex` decoder and fixed `BUTTONS` concatenation in the core top levels. It sits between `hps_io` (`ps2_key`, `joystick_0|1`) and the machine core. It drives an active-low button vector of configurable width. Each button takes its key codes and joystick bit from a run-time programmable map table, and selected buttons (coin) get guaranteed minimum-width pulses.

## Interface
- `NUM_BTN`, 8: number of output buttons (1..16).
- `JOY_W`, 16: joystick vector width.
- `PULSE_MASK`, 8'b0000_0100: buttons subject to minimum-pulse stretching. Width is `NUM_BTN`.
- `PULSE_CYC`, 16: minimum asserted length in clocks (1..255).

- `clk_25` in 1: system clock, all logic on rising edge.
- `RESET_L` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: [10] toggle strobe, [9] pressed, [8:0] code (bit 8 = extended).
- `joy` in `JOY_W`: OR of joystick ports, active-high.
- `map_wr` in 1: table write strobe.
- `map_addr` in $clog2(NUM_BTN)+2: {button, slot}. Slot 0 is key A, slot 1 is key B, slot 2 is joystick, slot 3 is reserved and ignored.
- `map_data` in 11: key slot {valid, any_ext, code[8:0]}; joystick slot {valid, 5'b0, bit[4:0]}.
- `btn_n` out `NUM_BTN`: active-low button states, registered.
- `busy` out 1: scan FSM not IDLE.
- `overflow` out 1: sticky, a key event was dropped. Cleared only by reset.

## Operation
- Event detect: `old_tgl` register. An event occurs when `ps2_key[10] != old_tgl`. The event {pressed, code} is captured in the same cycle.
- Event buffer is one pending slot.
  - If an event arrives while in IDLE with no pending event, the scan starts.
  - If an event arrives while in SCAN and the pending slot is empty, it is stored as pending.
  - If an event arrives while in SCAN and the pending slot is full, it is dropped and `overflow` is set to 1.
- FSM states:
  - IDLE goes to SCAN on an event or a pending event. A pending event takes priority over a same-cycle new event; the new event then becomes pending.
  - SCAN walks index i = 0..NUM_BTN-1, one button per cycle, and compares slots A and B.
  - At i = NUM_BTN-1, SCAN goes to IDLE. If pending is full, it goes straight back to SCAN (index 0, pending event loaded).
- Key match: the entry is valid and code[7:0] matches. Bit 8 must also match unless `any_ext` = 1. On a match, `kst[i][slot] <= pressed`. All matching entries update, so one code may drive several buttons.
- Joystick: `jhit[i]` = valid & `joy[bit]`. This is evaluated every cycle and is independent of the FSM. A bit index ≥ `JOY_W` is treated as invalid.
- Raw press: `p[i]` = `kst[i][0]` | `kst[i][1]` | `jhit[i]`.
- Stretch, for buttons with their `PULSE_MASK` bit set:
  - An 8-bit counter loads `PULSE_CYC`-1 on the rising edge of `p[i]`.
  - It decrements to 0.
  - The stretched press is `p[i]` | (cnt≠0) | (rising-edge cycle).
- `btn_n[i] <= ~pressed_final[i]`.
- Table writes are accepted in any state and take effect the next cycle. A compare in the write cycle uses the old value. Writing an entry invalid does not clear `kst`; the state is cleared by that key's break or by reset.
- Reset (any time, including mid-scan):
  - `btn_n` = all ones, `busy` = 0, `overflow` = 0.
  - Table all invalid, `kst` = 0, counters 0, pending empty, FSM IDLE.
  - `old_tgl` = 0.

## Timing
- Event detected in cycle T. Scan index i is compared in cycle T+1+i. `btn_n[i]` changes at T+2+i.
- The worst-case key-to-output delay is NUM_BTN+1 cycles.
- Joystick path: `joy` changes in cycle T, `btn_n` changes at T+1.
- `busy` = 1 from T+1 through T+NUM_BTN. Back-to-back service of a pending event keeps `busy` high with no gap.
- Stretched button: it is low for exactly max(`PULSE_CYC`, raw length) cycles, starting 1 cycle after the raw rise.

## Structure
- `input_mapper_pkg`: slot constants (SLOT_KEY_A=0, SLOT_KEY_B=1, SLOT_JOY=2), the entry struct {valid, any_ext, code[8:0]}, and FSM state enum {IDLE, SCAN}.
- Sub-module `input_map_table`: `NUM_BTN`×3 entry register file. It has one write port and two combinational read ports (slots A/B at the scan index) plus a parallel joystick-slot read for all buttons.
- The top holds the event detect, pending buffer, FSM, `kst`, stretch counters and output register.

## Test plan
- Reset with `ps2_key` toggling → `btn_n` = 8'hFF, `busy` = 0, `overflow` = 0; no table match occurs.
- Program btn7 slot A = {1,0,9'h03A}. A make of 9'h03A at T → `btn_n[7]` = 0 at T+9. A break → `btn_n[7]` = 1 at T+9.
- btn6 slot A = {1,1,9'h06B}. Makes of 9'h06B and 9'h16B both press it. With `any_ext` = 0, 9'h16B is ignored.
- Three events in cycles T, T+1, T+2 → the first two are applied in order and `busy` stays high for 16 cycles. The third is dropped and `overflow` = 1 and stays 1.
- btn2 (pulse, `PULSE_CYC` = 16) joystick slot = `joy[7]`. A 1-cycle `joy[7]` pulse → `btn_n[2]` is low for exactly 16 cycles. A 40-cycle hold → low for 40 cycles.
- btn0 slot A = 9'h06B, slot B = 9'h074, joystick = `joy[0]`. Press both keys and `joy[0]`, then release one key and `joy[0]` → btn0 stays pressed. Release the last key → `btn_n[0]` = 1.
